sumador_param: RTL and testbench

Parametrised up/down accumulating counter, the successor to the fixed 8-bit enable-driven sumador. Each enabled cycle it adds or subtracts a programmable step. It supports synchronous load, a choice of wrap-around or saturating arithmetic, a one-cycle boundary-event pulse and a sticky overflow flag. It sits behind the Tiny Tapeout top wrapper: `ui_in`/`uio_in` drive the controls and step, and `count` drives `uo_out`.

---
 rtl/sumador_param.sv | 89 ++++++++
 tb/tb_sumador_param.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/sumador_param.sv
// sumador_param: parametrised up/down accumulating counter with programmable
// step, synchronous load, wrap or saturate arithmetic, a one-cycle boundary
// event pulse and a sticky overflow flag.
module sumador_param #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             up_dn,
  input  logic             sat_mode,
  input  logic [WIDTH-1:0] step,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             evt,
  output logic             ovf
);

  localparam int unsigned EXT_W = WIDTH + 1;
  localparam logic [WIDTH-1:0] RST_COUNT = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_COUNT = {WIDTH{1'b0}};

  logic [EXT_W-1:0] sum_ext_c;
  logic [EXT_W-1:0] diff_ext_c;
  logic             up_evt_c;
  logic             dn_evt_c;
  logic             step_evt_c;
  logic [WIDTH-1:0] wrap_val_c;
  logic [WIDTH-1:0] clamp_val_c;
  logic [WIDTH-1:0] step_val_c;
  logic [WIDTH-1:0] count_nxt_c;
  logic             evt_nxt_c;
  logic             ovf_set_c;
  logic             ovf_nxt_c;

  // Widened arithmetic: carry-out flags an up crossing, borrow a down crossing
  always_comb begin
    sum_ext_c  = {1'b0, count} + {1'b0, step};
    diff_ext_c = {1'b0, count} - {1'b0, step};
    up_evt_c   = sum_ext_c[WIDTH];
    dn_evt_c   = diff_ext_c[WIDTH];
  end

  // Select the stepped value for the current direction and arithmetic mode
  always_comb begin
    step_evt_c  = up_dn ? up_evt_c : dn_evt_c;
    wrap_val_c  = up_dn ? sum_ext_c[WIDTH-1:0] : diff_ext_c[WIDTH-1:0];
    clamp_val_c = up_dn ? MAX_COUNT : MIN_COUNT;
    if (sat_mode && step_evt_c) begin
      step_val_c = clamp_val_c;
    end else begin
      step_val_c = wrap_val_c;
    end
  end

  // Next-state selection: load beats enable, otherwise hold
  always_comb begin
    count_nxt_c = count;
    evt_nxt_c   = 1'b0;
    ovf_set_c   = 1'b0;
    if (load) begin
      count_nxt_c = load_val;
    end else if (enable) begin
      count_nxt_c = step_val_c;
      evt_nxt_c   = step_evt_c;
      ovf_set_c   = step_evt_c;
    end
    // A new event wins over a simultaneous clear
    ovf_nxt_c = ovf_set_c | (ovf & ~clr_ovf);
  end

  // Output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= RST_COUNT;
      evt   <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      count <= count_nxt_c;
      evt   <= evt_nxt_c;
      ovf   <= ovf_nxt_c;
    end
  end

endmodule

// File: tb/tb_sumador_param.sv
// Directed self-checking bench for sumador_param: an 8-bit default instance
// and a 4-bit instance with non-zero reset value.
module tb_sumador_param;

  logic clk;
  int   n_checks;
  int   n_errors;

  // 8-bit instance signals
  logic       rst_n, enable, up_dn, sat_mode, load, clr_ovf;
  logic [7:0] step, load_val;
  logic [7:0] count;
  logic       evt, ovf;

  // 4-bit instance signals
  logic       r4_rst_n, r4_enable, r4_up_dn, r4_sat_mode, r4_load, r4_clr_ovf;
  logic [3:0] r4_step, r4_load_val;
  logic [3:0] r4_count;
  logic       r4_evt, r4_ovf;

  sumador_param #(.WIDTH(8), .RST_VAL(0)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .up_dn(up_dn),
    .sat_mode(sat_mode), .step(step), .load(load), .load_val(load_val),
    .clr_ovf(clr_ovf), .count(count), .evt(evt), .ovf(ovf)
  );

  sumador_param #(.WIDTH(4), .RST_VAL(5)) u_dut4 (
    .clk(clk), .rst_n(r4_rst_n), .enable(r4_enable), .up_dn(r4_up_dn),
    .sat_mode(r4_sat_mode), .step(r4_step), .load(r4_load),
    .load_val(r4_load_val), .clr_ovf(r4_clr_ovf), .count(r4_count),
    .evt(r4_evt), .ovf(r4_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock and settle just after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check8(input string tag, input logic [7:0] c, input logic e, input logic o);
    check({tag, ".count"}, 32'(count), 32'(c));
    check({tag, ".evt"},   32'(evt),   32'(e));
    check({tag, ".ovf"},   32'(ovf),   32'(o));
  endtask

  task automatic check4(input string tag, input logic [3:0] c, input logic e, input logic o);
    check({tag, ".count"}, 32'(r4_count), 32'(c));
    check({tag, ".evt"},   32'(r4_evt),   32'(e));
    check({tag, ".ovf"},   32'(r4_ovf),   32'(o));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0; enable = 1'b0; up_dn = 1'b1; sat_mode = 1'b0;
    load = 1'b0; clr_ovf = 1'b0; step = 8'h00; load_val = 8'h00;
    r4_rst_n = 1'b0; r4_enable = 1'b0; r4_up_dn = 1'b1; r4_sat_mode = 1'b0;
    r4_load = 1'b0; r4_clr_ovf = 1'b0; r4_step = 4'h0; r4_load_val = 4'h0;

    // Reset held for two cycles
    tick();
    tick();
    check8("reset", 8'h00, 1'b0, 1'b0);

    // Count up by one for 256 cycles: wraps to 0x00 with a single event
    rst_n = 1'b1; enable = 1'b1; up_dn = 1'b1; step = 8'h01; sat_mode = 1'b0;
    for (int k = 1; k <= 256; k++) begin
      tick();
      check8("count_up", 8'(k), (k == 256), (k == 256));
    end

    // Load 0x02 then step down by 3 in wrap mode
    enable = 1'b0; load = 1'b1; load_val = 8'h02;
    tick();
    check8("load_02", 8'h02, 1'b0, 1'b1);
    load = 1'b0; enable = 1'b1; up_dn = 1'b0; step = 8'h03;
    tick();
    check8("down_wrap", 8'hFF, 1'b1, 1'b1);
    enable = 1'b0; clr_ovf = 1'b1;
    tick();
    check8("clr_ovf", 8'hFF, 1'b0, 1'b0);
    clr_ovf = 1'b0;

    // Saturate up from 0xFE with step 5 for three cycles
    load = 1'b1; load_val = 8'hFE;
    tick();
    check8("load_fe", 8'hFE, 1'b0, 1'b0);
    load = 1'b0; enable = 1'b1; up_dn = 1'b1; step = 8'h05; sat_mode = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check8("sat_up", 8'hFF, 1'b1, 1'b1);
    end

    // Saturate down from 0x03 with step 7
    enable = 1'b0; load = 1'b1; load_val = 8'h03;
    tick();
    check8("load_03", 8'h03, 1'b0, 1'b1);
    load = 1'b0; enable = 1'b1; up_dn = 1'b0; step = 8'h07;
    tick();
    check8("sat_down", 8'h00, 1'b1, 1'b1);

    // Saturate mode without a crossing takes the exact result
    enable = 1'b0; load = 1'b1; load_val = 8'h10; clr_ovf = 1'b1;
    tick();
    check8("load_10", 8'h10, 1'b0, 1'b0);
    load = 1'b0; clr_ovf = 1'b0; enable = 1'b1; up_dn = 1'b1; step = 8'h05;
    tick();
    check8("sat_exact", 8'h15, 1'b0, 1'b0);

    // Load and enable together: load wins
    load = 1'b1; load_val = 8'h40; enable = 1'b1; step = 8'h09; sat_mode = 1'b0;
    tick();
    check8("load_prio", 8'h40, 1'b0, 1'b0);

    // Back-to-back loads, then a step from the second loaded value
    load_val = 8'h11;
    tick();
    check8("b2b_load1", 8'h11, 1'b0, 1'b0);
    load_val = 8'h22;
    tick();
    check8("b2b_load2", 8'h22, 1'b0, 1'b0);
    load = 1'b0; step = 8'h09;
    tick();
    check8("step_after_load", 8'h2B, 1'b0, 1'b0);

    // Wrap with clr_ovf asserted the same cycle: set wins
    enable = 1'b0; load = 1'b1; load_val = 8'hFE;
    tick();
    load = 1'b0; enable = 1'b1; up_dn = 1'b1; step = 8'h03; clr_ovf = 1'b1;
    tick();
    check8("clr_vs_set", 8'h01, 1'b1, 1'b1);
    clr_ovf = 1'b0;

    // Zero step with enable held: count holds, no event
    step = 8'h00;
    tick();
    check8("step0_a", 8'h01, 1'b0, 1'b1);
    up_dn = 1'b0; sat_mode = 1'b1;
    tick();
    check8("step0_b", 8'h01, 1'b0, 1'b1);
    enable = 1'b0;

    // 4-bit instance with RST_VAL=5
    tick();
    check4("r4_reset", 4'h5, 1'b0, 1'b0);
    r4_rst_n = 1'b1; r4_load = 1'b1; r4_load_val = 4'hF;
    tick();
    check4("r4_load_f", 4'hF, 1'b0, 1'b0);
    r4_load = 1'b0; r4_enable = 1'b1; r4_up_dn = 1'b1; r4_step = 4'h1;
    tick();
    check4("r4_wrap", 4'h0, 1'b1, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      tick();
    end
    check4("r4_at_a", 4'hA, 1'b0, 1'b1);

    // Reset mid-operation overrides a simultaneous load and enable
    r4_rst_n = 1'b0; r4_load = 1'b1; r4_load_val = 4'h3;
    tick();
    check4("r4_mid_reset", 4'h5, 1'b0, 1'b0);

    // First step after reset release applies at that edge
    r4_rst_n = 1'b1; r4_load = 1'b0; r4_enable = 1'b1; r4_step = 4'hF;
    r4_up_dn = 1'b1; r4_sat_mode = 1'b0;
    tick();
    check4("r4_post_reset", 4'h4, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
